// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//
// Purpose: generates VGA raster timing (800x525 total, 640x480 visible by
// default) and decides which of four test patterns the downstream pattern
// mux should show. Patterns rotate automatically every FRAMES_PER_PATTERN
// frames. The user can freeze the rotation with hold and advance it by one
// pattern per frame with step_req. Every pattern change happens at a frame
// boundary, so no frame ever shows two patterns.
//
// Parameters:
//   FRAMES_PER_PATTERN  frames each pattern is shown in auto mode (1..255)
//   H_* / V_*           raster geometry. Visible, front porch, sync and back
//                       porch lengths in pixels or lines. The defaults give
//                       standard 640x480@60.
//
// Ports:
//   clk          system clock; all state updates on its rising edge
//   reset        synchronous, active-high reset
//   pix_en       pixel-rate tick; counters advance only when it is 1
//   hold         level request to freeze the pattern rotation
//   step_req     single-cycle request to advance one pattern while held
//   x, y         current pixel coordinate (registered counter values)
//   hsync        active-low horizontal sync
//   vsync        active-low vertical sync
//   video_on     1 inside the visible area
//   frame_start  one-clk pulse when the counters move to (0,0)
//   pattern_sel  selected pattern ID
//   held         1 while the rotation is frozen (HOLD or STEP)

module vga_pattern_sequencer #(
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hold,
  input  logic       step_req,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic [1:0] pattern_sel,
  output logic       held
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {
    AUTO = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t     state;
  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic [7:0] frame_cnt;
  logic       step_pending;
  logic       frame_end;

  assign x = h;
  assign y = v;

  // Next raster position. Sync and video_on are registered from this next
  // position so they stay aligned with the registered x/y.
  always_comb begin
    h_next    = h;
    v_next    = v;
    frame_end = 1'b0;
    if (pix_en) begin
      if (h == H_LAST) begin
        h_next = 10'd0;
        if (v == V_LAST) begin
          v_next    = 10'd0;
          frame_end = 1'b1;
        end else begin
          v_next = v + 10'd1;
        end
      end else begin
        h_next = h + 10'd1;
      end
    end
  end

  // Raster counters and timing outputs. Without a pix_en tick the next
  // values equal the current ones, so everything holds. frame_start is a
  // pulse and is cleared on the following clock whether or not it is a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= 10'd0;
      v           <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h           <= h_next;
      v           <= v_next;
      hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
      vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
      video_on    <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
      frame_start <= frame_end;
    end
  end

  // Pattern rotation FSM. Mode and pattern changes are applied only on the
  // frame_end tick. Between frame ends, only the step request latch moves.
  // While held, one pending flag is kept, so extra step pulses in the same
  // frame collapse into a single step. Dropping hold wins over a pending
  // step. The AUTO frame count compares with >= so an out-of-range count
  // still wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= AUTO;
      frame_cnt    <= 8'd0;
      pattern_sel  <= 2'd0;
      step_pending <= 1'b0;
      held         <= 1'b0;
    end else if (frame_end) begin
      unique case (state)
        AUTO: begin
          if (hold) begin
            state     <= HOLD;
            held      <= 1'b1;
            frame_cnt <= 8'd0;
          end else if (frame_cnt >= FRAME_LAST) begin
            frame_cnt   <= 8'd0;
            pattern_sel <= pattern_sel + 2'd1;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!hold) begin
            state        <= AUTO;
            held         <= 1'b0;
            frame_cnt    <= 8'd0;
            step_pending <= 1'b0;
          end else if (step_pending) begin
            state        <= STEP;
            pattern_sel  <= pattern_sel + 2'd1;
            step_pending <= 1'b0;
          end else begin
            step_pending <= step_req;
          end
        end
        STEP: begin
          frame_cnt <= 8'd0;
          if (hold) begin
            state <= HOLD;
          end else begin
            state <= AUTO;
            held  <= 1'b0;
          end
        end
        default: begin
          state        <= AUTO;
          held         <= 1'b0;
          frame_cnt    <= 8'd0;
          step_pending <= 1'b0;
        end
      endcase
    end else if ((state == HOLD) && step_req) begin
      step_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer
//
// Purpose: exercises vga_pattern_sequencer with a shrunken raster
// (25x15 total) so that many whole frames fit in a short run.
//
// The reference model describes the raster as a single tick index within
// the frame. Coordinates and sync come from division and ranges. The
// pattern logic is described frame by frame. Each clock the model pushes
// the expected outputs into a queue, and each frame end it pushes the
// expected pattern. A monitor pops the per-clock queue every cycle and pops
// the frame queue whenever the DUT raises frame_start.

module tb_vga_pattern_sequencer;

  localparam int FPP = 2;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam int M_AUTO = 0, M_HOLD = 1, M_STEP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hold = 1'b0;
  logic       step_req = 1'b0;
  logic [9:0] x, y;
  logic       hsync, vsync, video_on, frame_start, held;
  logic [1:0] pattern_sel;

  always #5 clk = ~clk;

  vga_pattern_sequencer #(
    .FRAMES_PER_PATTERN(FPP),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .hold(hold),
    .step_req(step_req),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .frame_start(frame_start),
    .pattern_sel(pattern_sel),
    .held(held)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time,
               actual, expected);
    end
  endtask

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [1:0] sel;
    logic       held;
  } exp_t;

  exp_t exp_q[$];
  int   sel_q[$];

  // Reference model state
  int m_tick = 0;
  int m_shown = 0;
  int m_sel = 0;
  int m_mode = M_AUTO;
  bit m_pend = 0;
  bit m_live = 0;

  // Behavioural model: sees the same inputs the DUT samples at this edge.
  always @(posedge clk) begin
    exp_t e;
    bit   fe;
    int   hpos, vpos;
    fe = m_live && !reset && pix_en && (m_tick == FRAME - 1);
    if (reset) begin
      m_tick = 0; m_shown = 0; m_sel = 0; m_mode = M_AUTO; m_pend = 0;
      m_live = 1;
    end else if (m_live) begin
      if (pix_en) m_tick = (m_tick + 1) % FRAME;
      if (fe) begin
        if (m_mode == M_AUTO) begin
          if (hold) begin
            m_mode = M_HOLD; m_shown = 0;
          end else begin
            m_shown++;
            if (m_shown == FPP) begin
              m_shown = 0; m_sel = (m_sel + 1) % 4;
            end
          end
        end else if (m_mode == M_HOLD) begin
          if (!hold) begin
            m_mode = M_AUTO; m_shown = 0; m_pend = 0;
          end else if (m_pend) begin
            m_mode = M_STEP; m_sel = (m_sel + 1) % 4; m_pend = 0;
          end else begin
            m_pend = step_req;
          end
        end else begin
          m_mode = hold ? M_HOLD : M_AUTO; m_shown = 0;
        end
        sel_q.push_back(m_sel);
      end else if (m_mode == M_HOLD && step_req) begin
        m_pend = 1;
      end
    end
    if (m_live) begin
      hpos = m_tick % HT;
      vpos = m_tick / HT;
      e.x = 10'(hpos);
      e.y = 10'(vpos);
      e.hsync = !(hpos >= HV + HF && hpos < HV + HF + HS);
      e.vsync = !(vpos >= VV + VF && vpos < VV + VF + VS);
      e.video_on = (hpos < HV) && (vpos < VV);
      e.frame_start = fe;
      e.sel = 2'(m_sel);
      e.held = (m_mode != M_AUTO);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares every clock, and checks the pattern on each frame_start.
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    int   want_sel;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {x, y, hsync, vsync, video_on, frame_start, pattern_sel, held};
      checkOutput("cycle_outputs", 32'(a), 32'(e));
    end
    if (frame_start === 1'b1) begin
      want_sel = (sel_q.size() != 0) ? sel_q.pop_front() : -1;
      checkOutput("frame_sel", 32'(pattern_sel), want_sel);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Driver
  int   tpos = 0;
  logic hold_lvl = 1'b0;

  task automatic applyStimulus(input logic pe, input logic sr);
    pix_en = pe;
    hold = hold_lvl;
    step_req = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic runTicks(input int n, input int gate);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < gate - 1; j++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      tpos = (tpos + 1) % FRAME;
    end
  endtask

  task automatic runToFrameStart(input int gate);
    do runTicks(1, gate); while (tpos != 0);
  endtask

  task automatic stepPulse();
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    tpos = 0;
  endtask

  int vid_cnt, hs_low, vs_low, fs_cnt, fs_first, fs_second;
  int rot_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  initial begin
    $display("[TB] start");
    // Reset state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    checkOutput("reset_x", 32'(x), 0);
    checkOutput("reset_y", 32'(y), 0);
    checkOutput("reset_sel", 32'(pattern_sel), 0);
    checkOutput("reset_held", 32'(held), 0);
    checkOutput("reset_frame_start", 32'(frame_start), 0);
    checkOutput("reset_syncs_video", {29'd0, hsync, vsync, video_on}, 3'b111);

    // Timing over two frames with pix_en every clock
    vid_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = 0; fs_second = 0;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (video_on === 1'b1) vid_cnt++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = k; else fs_second = k;
      end
    end
    tpos = 0;
    checkOutput("video_on_cycles", vid_cnt, 2 * HV * VV);
    checkOutput("hsync_low_cycles", hs_low, 2 * HS * VT);
    checkOutput("vsync_low_cycles", vs_low, 2 * VS * HT);
    checkOutput("frame_start_count", fs_cnt, 2);
    checkOutput("first_frame_len", fs_first, FRAME);
    checkOutput("frame_period", fs_second - fs_first, FRAME);

    // Auto rotation over nine frames
    doReset();
    checkOutput("rot_sel_0", 32'(pattern_sel), rot_seq[0]);
    for (int f = 1; f < 9; f++) begin
      runToFrameStart(1);
      checkOutput("rot_frame_start", 32'(frame_start), 1);
      checkOutput("rot_sel", 32'(pattern_sel), rot_seq[f]);
    end
    runToFrameStart(1);

    // Hold asserted mid-frame, pix_en at 1-in-4. The AUTO advance that
    // would have happened at this boundary must be suppressed.
    runTicks(FRAME / 2, 4);
    hold_lvl = 1'b1;
    runToFrameStart(4);
    checkOutput("hold_entry_sel", 32'(pattern_sel), 0);
    checkOutput("hold_entry_held", 32'(held), 1);
    runTicks(50, 4);
    stepPulse();
    runTicks(20, 4);
    stepPulse();
    runTicks(20, 4);
    stepPulse();
    checkOutput("held_during_steps", 32'(held), 1);
    runToFrameStart(4);
    checkOutput("step_sel", 32'(pattern_sel), 1);
    checkOutput("step_held", 32'(held), 1);
    runToFrameStart(4);
    checkOutput("back_to_hold_sel", 32'(pattern_sel), 1);

    // Step and release in the same frame: release wins
    runTicks(40, 2);
    stepPulse();
    runTicks(10, 2);
    hold_lvl = 1'b0;
    runToFrameStart(2);
    checkOutput("release_sel", 32'(pattern_sel), 1);
    checkOutput("release_held", 32'(held), 0);
    runToFrameStart(2);
    checkOutput("auto_after_release_sel", 32'(pattern_sel), 1);
    runToFrameStart(2);
    checkOutput("auto_resume_sel", 32'(pattern_sel), 2);

    // Random soak
    for (int c = 0; c < 8 * FRAME; c++) begin
      logic pe, sr;
      if ($urandom_range(0, 199) == 0) hold_lvl = !hold_lvl;
      pe = 1'($urandom_range(0, 1));
      sr = ($urandom_range(0, 39) == 0);
      applyStimulus(pe, sr);
      if (pe) tpos = (tpos + 1) % FRAME;
    end
    hold_lvl = 1'b0;

    // Mid-frame reset with pattern 2 selected
    doReset();
    for (int f = 0; f < 4; f++) runToFrameStart(1);
    checkOutput("pre_reset_sel", 32'(pattern_sel), 2);
    runTicks(7 * HT + 12, 1);
    checkOutput("pre_reset_x", 32'(x), 12);
    checkOutput("pre_reset_y", 32'(y), 7);
    reset = 1'b1;
    hold_lvl = 1'b1;
    applyStimulus(1'b1, 1'b1);
    reset = 1'b0;
    hold_lvl = 1'b0;
    tpos = 0;
    checkOutput("mid_reset_x", 32'(x), 0);
    checkOutput("mid_reset_y", 32'(y), 0);
    checkOutput("mid_reset_sel", 32'(pattern_sel), 0);
    checkOutput("mid_reset_held", 32'(held), 0);
    runTicks(30, 1);
    checkOutput("resume_x", 32'(x), 5);
    checkOutput("resume_y", 32'(y), 1);

    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("frame_queue_drained", sel_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_pattern_sequencer.md
VGA_PATTERN_SEQUENCER -- requirements
Module: vga_pattern_sequencer

Interface
REQ-001 The block SHALL have parameter FRAMES_PER_PATTERN, default 60, meaning the number of frames each pattern is shown in auto mode (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port pix_en, input, 1 bit: pixel-rate tick; counters advance only on cycles with pix_en=1.
REQ-005 The block SHALL have port hold, input, 1 bit: level request to freeze the pattern rotation.
REQ-006 The block SHALL have port step_req, input, 1 bit: single-cycle request to advance one pattern while held.
REQ-007 The block SHALL have port x, output, 10 bits: the current horizontal pixel coordinate to the pattern generator.
REQ-008 The block SHALL have port y, output, 10 bits: the current vertical pixel coordinate to the pattern generator.
REQ-009 The block SHALL have port hsync, output, 1 bit: active-low horizontal sync.
REQ-010 The block SHALL have port vsync, output, 1 bit: active-low vertical sync.
REQ-011 The block SHALL have port video_on, output, 1 bit: 1 inside the 640x480 visible area.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-clk pulse when the counters move to (0,0).
REQ-013 The block SHALL have port pattern_sel, output, 2 bits: the selected pattern ID for the pattern mux.
REQ-014 The block SHALL have port held, output, 1 bit: 1 while the FSM is in HOLD or STEP.

Function
REQ-015 The horizontal counter h SHALL count 0..799 and wrap to 0 on a pix_en cycle at 799; the vertical counter v SHALL increment when h wraps, count 0..524 and wrap to 0.
REQ-016 Outputs SHALL be x=h and y=v, both registered counter values; video_on SHALL be (h<640 && v<480).
REQ-017 hsync SHALL be 0 for h in 656..751, else 1; vsync SHALL be 0 for v in 490..491, else 1.
REQ-018 Frame end SHALL be the pix_en cycle with h=799 and v=524; frame_start SHALL be 1 for exactly the following clk.
REQ-019 The FSM SHALL have states AUTO, HOLD and STEP; all state and pattern_sel changes SHALL occur only at frame end, never mid-frame.
REQ-020 In AUTO, the 8-bit frame counter SHALL increment at each frame end; at value FRAMES_PER_PATTERN-1 it SHALL wrap to 0 and pattern_sel SHALL increment mod 4 (3->0).
REQ-021 In AUTO with hold=1 at frame end, the FSM SHALL go to HOLD, clear the frame counter and keep pattern_sel; the AUTO advance SHALL NOT also occur at that boundary.
REQ-022 A step_req pulse seen in HOLD SHALL set a pending flag; further pulses before frame end SHALL be ignored, so at most one step occurs per frame.
REQ-023 In HOLD at frame end with the pending flag set, the FSM SHALL enter STEP; pattern_sel SHALL increment mod 4 and the flag SHALL clear at that same boundary.
REQ-024 STEP SHALL return to HOLD at the next frame end if hold=1, otherwise to AUTO with the frame counter at 0.
REQ-025 In HOLD with hold=0 at frame end, the FSM SHALL go to AUTO with the frame counter at 0; a pending step SHALL be discarded (release beats step).
REQ-026 step_req in AUTO SHALL be ignored.
REQ-027 With pix_en=0, the counters, FSM and all outputs SHALL hold their values.

Reset
REQ-028 reset=1 SHALL force, on the next clk edge: h=v=0, frame counter 0, pattern_sel 0, FSM AUTO, pending flag 0, frame_start 0 and held 0; hsync, vsync and video_on then follow from h=v=0 (1, 1, 1).
REQ-029 Reset asserted mid-frame SHALL take priority over pix_en and all requests; counting SHALL resume from (0,0) on the first pix_en after release.

Verification
REQ-030 Bench SHALL check timing: with pix_en=1 every clk, run 2 frames -> 420000 pix_en cycles per frame; hsync low for 96 cycles per line; vsync low for 2 lines; video_on high for 307200 cycles per frame.
REQ-031 Bench SHALL check auto rotation: with FRAMES_PER_PATTERN=2 and hold=0, run 9 frames -> pattern_sel 0,0,1,1,2,2,3,3,0, changing only on the frame_start cycle.
REQ-032 Bench SHALL check hold and step: assert hold mid-frame, then give 3 step_req pulses in one frame -> pattern_sel advances by exactly 1 at the next frame end and held=1 throughout.
REQ-033 Bench SHALL check simultaneous events: in HOLD, pulse step_req and drop hold in the same frame -> AUTO at frame end, pattern_sel unchanged, held=0.
REQ-034 Bench SHALL check reset: assert reset at h=300, v=200 with pattern_sel=2 -> next clk gives x=0, y=0, pattern_sel=0, held=0.
REQ-035 Bench SHALL check gating: with pix_en at 1-in-4 clk, all outputs are stable for the 3 clks between ticks, and frame_start is exactly one clk wide.
